// File: rtl/calc_pkg.sv
// Purpose: shared state encoding and default sizing for the calculation sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package calc_pkg;

  localparam int DEF_NUM_ROWS    = 10;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_CALC = 3'd1,
    MUL        = 3'd2,
    MUL_DONE   = 3'd3,
    WRITE_OUT  = 3'd4,
    ERROR      = 3'd5
  } state_t;

endpackage

// File: rtl/calc_sequencer_row_timer.sv
// Purpose: per-row watchdog; counts cycles spent on one row and flags the last allowed cycle.
// Latency: tc is combinational from the registered count; clear takes effect on the next edge.
// Backpressure: none; enable simply stalls at the terminal count, TIMEOUT_CYC=0 never flags.
module row_timer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // Count only needs to reach TIMEOUT_CYC-1: that cycle is the last one a row may take.
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit ENABLED = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] count;

  // Cycle counter: clear wins over counting, saturates at the terminal value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Purpose: steps a multiplier through result rows 0..rows-1 and signals completion or row timeout.
// Latency: first begin_mult two cycles after data_stored goes high; done_calc two cycles after last done_row.
// Backpressure: each row is held until done_row; abort cancels from any non-idle state.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              data_stored,
  input  logic [ADDR_W:0]   row_count,
  input  logic              done_row,
  input  logic              abort,
  output logic [ADDR_W-1:0] res_add,
  output logic              begin_mult,
  output logic              done_calc,
  output logic              busy,
  output logic              err_timeout
);

  // Row totals can equal 2^ADDR_W, so they carry one extra bit over the address.
  localparam int ROWS_W = ADDR_W + 1;
  localparam logic [ROWS_W-1:0] MAX_ROWS = ROWS_W'(NUM_ROWS);

  state_t            state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] nxt_row;
  logic [ROWS_W-1:0] rows_latched;
  logic [ROWS_W-1:0] nxt_rows;
  logic              last_row;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_tc;

  assign last_row  = (ROWS_W'(row) == (rows_latched - ROWS_W'(1)));
  assign timer_en  = (state == MUL);
  // Restarts on every fresh row: while outside MUL and on each accepted done_row.
  assign timer_clr = (state != MUL) || done_row;

  row_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_row_timer (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (timer_clr),
    .enable  (timer_en),
    .tc      (timer_tc)
  );

  // Next-state, row counter and row-total decode; abort overrides everything outside IDLE.
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_rows  = rows_latched;
    unique case (state)
      IDLE: begin
        if (data_stored && !abort) begin
          nxt_state = START_CALC;
          nxt_row   = '0;
          nxt_rows  = ((row_count == '0) || (row_count > MAX_ROWS)) ? MAX_ROWS : row_count;
        end
      end
      START_CALC: nxt_state = MUL;
      MUL: begin
        if (done_row) begin
          if (last_row) begin
            nxt_state = MUL_DONE;
          end else begin
            nxt_row = row + ADDR_W'(1);
          end
        end else if (timer_tc) begin
          nxt_state = ERROR;
        end
      end
      MUL_DONE:  nxt_state = WRITE_OUT;
      WRITE_OUT: nxt_state = IDLE;
      ERROR:     nxt_state = ERROR;
      default:   nxt_state = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      nxt_state = IDLE;
      nxt_row   = '0;
    end
  end

  // State registers plus Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      row          <= '0;
      rows_latched <= MAX_ROWS;
      res_add      <= '0;
      begin_mult   <= 1'b0;
      done_calc    <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= nxt_state;
      row          <= nxt_row;
      rows_latched <= nxt_rows;
      res_add      <= (nxt_state == MUL) ? nxt_row : '0;
      begin_mult   <= (nxt_state == MUL);
      done_calc    <= (nxt_state == WRITE_OUT);
      busy         <= (nxt_state != IDLE);
      err_timeout  <= (nxt_state == ERROR);
    end
  end

endmodule
